// File: rtl/tff_toggle_monitor.sv
// Toggle activity monitor for the TFF output Q.
// Counts rising/falling edges of q_in over a programmable window.
module tff_toggle_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             saturated,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    REPORT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             q_dly_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             rise, fall;

  assign rise = q_in & ~q_dly_q;
  assign fall = ~q_in & q_dly_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start && (window_len != '0)) begin
          state_d = MEASURE;
          win_d   = window_len;
          rise_d  = '0;
          fall_d  = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        // Counters stick at max; the lost edge is flagged instead.
        if (rise) begin
          if (rise_q == CNT_MAX) sat_d = 1'b1;
          else rise_d = rise_q + CNT_W'(1);
        end
        if (fall) begin
          if (fall_q == CNT_MAX) sat_d = 1'b1;
          else fall_d = fall_q + CNT_W'(1);
        end
        win_d = win_q - WIN_W'(1);
        if (win_q == WIN_W'(1)) begin
          state_d = REPORT;
          valid_d = 1'b1;
        end
      end
      REPORT: begin
        if (result_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_dly_q <= 1'b0;
      win_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_dly_q <= q_in;
      win_q   <= win_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign rise_cnt     = rise_q;
  assign fall_cnt     = fall_q;
  assign saturated    = sat_q;
  assign result_valid = valid_q;

endmodule
